// File: rtl/n_channel_arbitrated_mux.sv
// CHANNELS x BITS registered mux with direct-select or round-robin arbitration,
// request/grant handshake on the inputs and a valid/ready output register.
module n_channel_arbitrated_mux #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_BITS = $clog2(CHANNELS)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [CHANNELS-1:0][BITS-1:0] DATA,
    input  logic [CHANNELS-1:0]           REQUEST,
    output logic [CHANNELS-1:0]           GRANT,
    input  logic                          MODE,
    input  logic [SEL_BITS-1:0]           SELECT,
    output logic [BITS-1:0]               OUT,
    output logic [SEL_BITS-1:0]           OUT_CHANNEL,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY
);
    localparam int unsigned         IDX_BITS = SEL_BITS + 1;
    localparam logic [IDX_BITS-1:0] CH_COUNT = IDX_BITS'(CHANNELS);
    localparam logic [SEL_BITS-1:0] LAST_CH  = SEL_BITS'(CHANNELS - 1);

    logic [SEL_BITS-1:0] ptr;
    logic [SEL_BITS-1:0] ptr_nxt;
    logic [SEL_BITS-1:0] grant_idx;
    logic [SEL_BITS-1:0] rr_idx;
    logic [IDX_BITS-1:0] scan_idx;
    logic                armed;
    logic                free;
    logic                grant_any;
    logic                rr_hit;

    // Round-robin winner: first requester at or after ptr, wrapping modulo CHANNELS
    always_comb begin
        rr_hit   = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            scan_idx = IDX_BITS'(ptr) + IDX_BITS'(k);
            if (scan_idx >= CH_COUNT) begin
                scan_idx = scan_idx - CH_COUNT;
            end
            if (!rr_hit && REQUEST[SEL_BITS'(scan_idx)]) begin
                rr_hit = 1'b1;
                rr_idx = SEL_BITS'(scan_idx);
            end
        end
    end

    // Grant selection; armed stays low for the first edge after reset release
    always_comb begin
        free      = ~OUT_VALID | OUT_READY;
        grant_any = 1'b0;
        grant_idx = '0;
        ptr_nxt   = ptr;
        GRANT     = '0;
        if (armed && free) begin
            if (MODE) begin
                grant_any = rr_hit;
                grant_idx = rr_idx;
                if (rr_hit) begin
                    ptr_nxt = (rr_idx == LAST_CH) ? '0 : rr_idx + 1'b1;
                end
            end else if ((IDX_BITS'(SELECT) < CH_COUNT) && REQUEST[SELECT]) begin
                grant_any = 1'b1;
                grant_idx = SELECT;
            end
        end
        if (grant_any) begin
            GRANT = CHANNELS'(1) << grant_idx;
        end
    end

    // Output register: a grant loads a new word even while the old one drains
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            armed       <= 1'b0;
            ptr         <= '0;
            OUT         <= '0;
            OUT_CHANNEL <= '0;
            OUT_VALID   <= 1'b0;
        end else begin
            armed <= 1'b1;
            ptr   <= ptr_nxt;
            if (grant_any) begin
                OUT         <= DATA[grant_idx];
                OUT_CHANNEL <= grant_idx;
                OUT_VALID   <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_n_channel_arbitrated_mux.sv
// Bench for n_channel_arbitrated_mux: a 4-channel instance driven against a
// behavioural model with a scoreboard, and a 3-channel instance for wrap/range cases.
module tb_n_channel_arbitrated_mux;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  ch;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst4, rst3;
    logic [3:0][31:0] data4;
    logic [3:0]       req4, grant4;
    logic             mode4, ov4, ordy4;
    logic [1:0]       sel4, och4;
    logic [31:0]      out4;

    logic [2:0][31:0] data3;
    logic [2:0]       req3, grant3;
    logic             mode3, ov3, ordy3;
    logic [1:0]       sel3, och3;
    logic [31:0]      out3;

    n_channel_arbitrated_mux #(.BITS(32), .CHANNELS(4)) dut4 (
        .CLK(clk), .RESET(rst4), .DATA(data4), .REQUEST(req4), .GRANT(grant4),
        .MODE(mode4), .SELECT(sel4), .OUT(out4), .OUT_CHANNEL(och4),
        .OUT_VALID(ov4), .OUT_READY(ordy4)
    );

    n_channel_arbitrated_mux #(.BITS(32), .CHANNELS(3)) dut3 (
        .CLK(clk), .RESET(rst3), .DATA(data3), .REQUEST(req3), .GRANT(grant3),
        .MODE(mode3), .SELECT(sel3), .OUT(out3), .OUT_CHANNEL(och3),
        .OUT_VALID(ov3), .OUT_READY(ordy3)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb4[$];
    exp_t sb3[$];

    int   m_ptr;
    logic m_valid;
    logic m_armed;

    logic [31:0] exp_seq [5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10};
    logic [1:0]  exp_och [3] = '{2'd1, 2'd3, 2'd1};
    logic [1:0]  exp_ptr [3] = '{2'd2, 2'd0, 2'd2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle on the 4-channel instance: predict grant, push scoreboard, check after the edge
    task automatic cyc4(input logic [3:0] req, input logic mode, input logic [1:0] sel,
                        input logic ready);
        int         g;
        logic       free;
        logic [3:0] exp_g;
        exp_t       e;
        req4  = req;
        mode4 = mode;
        sel4  = sel;
        ordy4 = ready;
        #1;
        free = !m_valid || ready;
        g    = -1;
        if (m_armed && free) begin
            if (!mode) begin
                if (req[sel]) g = int'(sel);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (g < 0 && req[i]) g = i;
                end
            end
        end
        exp_g = (g >= 0) ? 4'(1 << g) : 4'd0;
        chk("grant4", 64'(grant4), 64'(exp_g));
        if (g >= 0) sb4.push_back({data4[g], 2'(g)});
        @(posedge clk);
        #1;
        m_armed = 1'b1;
        if (g >= 0) begin
            m_valid = 1'b1;
            if (mode) m_ptr = (g + 1) % 4;
            e = sb4.pop_front();
            chk("out4", 64'(out4), 64'(e.data));
            chk("och4", 64'(och4), 64'(e.ch));
        end else if (ready) begin
            m_valid = 1'b0;
        end
        chk("valid4", 64'(ov4), 64'(m_valid));
        chk("ptr4", 64'(dut4.ptr), 64'(m_ptr));
    endtask

    initial begin
        exp_t e;
        rst4 = 1'b1; rst3 = 1'b1;
        req4 = 4'hF; mode4 = 1'b1; sel4 = '0; ordy4 = 1'b1;
        for (int i = 0; i < 4; i++) data4[i] = 32'(i + 'h10);
        req3 = '0; mode3 = 1'b0; sel3 = '0; ordy3 = 1'b1;
        for (int i = 0; i < 3; i++) data3[i] = 32'(i + 'h20);
        m_ptr = 0; m_valid = 1'b0; m_armed = 1'b0;

        // Reset held with all channels requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant4), 64'd0);
        chk("rst_valid", 64'(ov4), 64'd0);
        chk("rst_out", 64'(out4), 64'd0);
        rst4 = 1'b0; rst3 = 1'b0;

        // Release cycle gives no grant, then round robin 10,11,12,13,10
        cyc4(4'hF, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc4(4'hF, 1'b1, 2'd0, 1'b1);
            chk("rr_seq", 64'(out4), 64'(exp_seq[i]));
        end

        // Async reset, then REQUEST=1010 from ptr 0
        rst4 = 1'b1;
        #1;
        chk("rst_async_valid", 64'(ov4), 64'd0);
        chk("rst_async_ptr", 64'(dut4.ptr), 64'd0);
        rst4 = 1'b0;
        m_ptr = 0; m_valid = 1'b0; m_armed = 1'b0;
        cyc4(4'b1010, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc4(4'b1010, 1'b1, 2'd0, 1'b1);
            chk("rr_1010_ch", 64'(och4), 64'(exp_och[i]));
            chk("rr_1010_ptr", 64'(dut4.ptr), 64'(exp_ptr[i]));
        end

        // Backpressure for three cycles, then drain and load on the same edge
        for (int i = 0; i < 3; i++) begin
            cyc4(4'hF, 1'b1, 2'd0, 1'b0);
            chk("bp_hold_out", 64'(out4), 64'h11);
        end
        cyc4(4'hF, 1'b1, 2'd0, 1'b1);
        chk("bp_release_out", 64'(out4), 64'h12);

        // Direct select: channel 2 not requesting, then requesting
        cyc4(4'b1011, 1'b0, 2'd2, 1'b1);
        chk("sel_nogrant_valid", 64'(ov4), 64'd0);
        cyc4(4'b0100, 1'b0, 2'd2, 1'b1);
        chk("sel_out", 64'(out4), 64'h12);
        chk("sel_ptr", 64'(dut4.ptr), 64'd3);

        // Mixed random traffic against the model
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 4; c++) data4[c] = $urandom;
            cyc4(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Three channels: out-of-range select, wrap of ptr, async reset mid-stream
        mode3 = 1'b0; sel3 = 2'd3; req3 = 3'b111; ordy3 = 1'b1;
        #1;
        chk("c3_sel3_grant", 64'(grant3), 64'd0);
        @(posedge clk);
        #1;
        chk("c3_sel3_valid", 64'(ov3), 64'd0);
        mode3 = 1'b1; req3 = 3'b100;
        #1;
        chk("c3_rr_grant2", 64'(grant3), 64'b100);
        sb3.push_back({data3[2], 2'd2});
        @(posedge clk);
        #1;
        e = sb3.pop_front();
        chk("c3_out", 64'(out3), 64'(e.data));
        chk("c3_och", 64'(och3), 64'(e.ch));
        chk("c3_valid", 64'(ov3), 64'd1);
        chk("c3_ptr_wrap", 64'(dut3.ptr), 64'd0);
        req3 = 3'b011;
        #1;
        chk("c3_rr_grant0", 64'(grant3), 64'b001);
        sb3.push_back({data3[0], 2'd0});
        @(posedge clk);
        #1;
        e = sb3.pop_front();
        chk("c3_out0", 64'(out3), 64'(e.data));
        chk("c3_ptr1", 64'(dut3.ptr), 64'd1);
        req3 = 3'b010;
        #2;
        rst3 = 1'b1;
        #1;
        chk("c3_rst_valid", 64'(ov3), 64'd0);
        chk("c3_rst_out", 64'(out3), 64'd0);
        chk("c3_rst_grant", 64'(grant3), 64'd0);
        chk("c3_rst_ptr", 64'(dut3.ptr), 64'd0);
        rst3 = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
